// File: rtl/buffer_pkg.sv
// Shared defaults, width helpers and output-format codes for the rotating
// multi-bank sample buffer.
package buffer_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 10;
   localparam int DEFAULT_BANK_DEPTH    = 8192;
   localparam int DEFAULT_NUM_BANKS     = 4;
   localparam int DEFAULT_OVERFLOW_HOLD = 1000;

   localparam logic DATA_MODE_ZERO_EXT  = 1'b0;
   localparam logic DATA_MODE_LEFT_JUST = 1'b1;

   function automatic int bankIndexWidth(input int numBanks);
      return (numBanks > 1) ? $clog2(numBanks) : 1;
   endfunction

   function automatic int addrWidth(input int bankDepth);
      return (bankDepth > 1) ? $clog2(bankDepth) : 1;
   endfunction

   function automatic int countWidth(input int numBanks);
      return $clog2(numBanks + 1);
   endfunction

endpackage

// File: rtl/multi_bank_buffer_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Kept as a bare array so every vendor flow infers block RAM from it.
module sdp_ram #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 1024,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             writeEnable,
   input  logic [AW-1:0]    writeAddr,
   input  logic [WIDTH-1:0] writeData,
   input  logic             readEnable,
   input  logic [AW-1:0]    readAddr,
   output logic [WIDTH-1:0] readData
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (writeEnable) mem[writeAddr] <= writeData;
      if (readEnable)  readData <= mem[readAddr];
   end

endmodule

// File: rtl/multi_bank_buffer.sv
// N-bank rotating sample buffer between ADC capture and USB transfer logic.
// The writer only ever advances into a free bank, so a ready bank is never clobbered.
module multi_bank_buffer
   import buffer_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int BANK_DEPTH    = DEFAULT_BANK_DEPTH,
   parameter int NUM_BANKS     = DEFAULT_NUM_BANKS,
   parameter int OVERFLOW_HOLD = DEFAULT_OVERFLOW_HOLD
) (
   input  logic                            clock,
   input  logic                            nReset,
   input  logic                            isWriting,
   input  logic [DATA_WIDTH-1:0]           dataIn,
   input  logic                            isReading,
   input  logic                            dataMode,
   output logic [15:0]                     dataOut,
   output logic                            dataValid,
   output logic                            dataAvailable,
   output logic [countWidth(NUM_BANKS)-1:0] banksReady,
   output logic                            bufferOverflow,
   output logic [15:0]                     overflowCount
);

   localparam int BW = bankIndexWidth(NUM_BANKS);
   localparam int AW = addrWidth(BANK_DEPTH);
   localparam int CW = countWidth(NUM_BANKS);
   localparam int HW = $clog2(OVERFLOW_HOLD + 1);
   localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(BANK_DEPTH - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(OVERFLOW_HOLD - 1);

   logic [BW-1:0]           writeBank, readBank, nextWriteBank, nextReadBank;
   logic [AW-1:0]           writeAddr, readAddr;
   logic [NUM_BANKS-1:0]    ready, nextReady;
   logic [CW-1:0]           nextBanksReady;
   logic [HW-1:0]           holdCount;
   logic                    doPop, finalPop, bankDone, nextFree, commitBank, overflowEvent;
   logic                    popSeen, readMode;
   logic [DATA_WIDTH-1:0]   ramWord;
   logic [15:0]             word16;

   sdp_ram #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (NUM_BANKS * BANK_DEPTH)
   ) u_ram (
      .clock       (clock),
      .writeEnable (isWriting),
      .writeAddr   ({writeBank, writeAddr}),
      .writeData   (dataIn),
      .readEnable  (doPop),
      .readAddr    ({readBank, readAddr}),
      .readData    (ramWord)
   );

   always_comb begin
      doPop         = isReading && dataAvailable;
      finalPop      = doPop && (readAddr == LAST_ADDR);
      bankDone      = isWriting && (writeAddr == LAST_ADDR);
      nextWriteBank = (writeBank == LAST_BANK) ? '0 : writeBank + 1'b1;
      nextReadBank  = (readBank == LAST_BANK) ? '0 : readBank + 1'b1;
      // A bank the reader releases this very cycle counts as free.
      nextFree      = !ready[nextWriteBank] || (finalPop && (readBank == nextWriteBank));
      commitBank    = bankDone && nextFree;
      overflowEvent = bankDone && !nextFree;

      nextReady = ready;
      if (finalPop)   nextReady[readBank]  = 1'b0;
      if (commitBank) nextReady[writeBank] = 1'b1;

      nextBanksReady = banksReady;
      if (commitBank && !finalPop)      nextBanksReady = banksReady + 1'b1;
      else if (!commitBank && finalPop) nextBanksReady = banksReady - 1'b1;
   end

   always_comb begin
      word16 = 16'(ramWord);
      if (!popSeen)                             dataOut = '0;
      else if (readMode == DATA_MODE_LEFT_JUST) dataOut = word16 << (16 - DATA_WIDTH);
      else                                      dataOut = word16;
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         writeBank      <= '0;
         writeAddr      <= '0;
         readBank       <= '0;
         readAddr       <= '0;
         ready          <= '0;
         banksReady     <= '0;
         dataAvailable  <= 1'b0;
         dataValid      <= 1'b0;
         popSeen        <= 1'b0;
         readMode       <= DATA_MODE_ZERO_EXT;
         bufferOverflow <= 1'b0;
         holdCount      <= '0;
         overflowCount  <= '0;
      end else begin
         ready         <= nextReady;
         banksReady    <= nextBanksReady;
         dataAvailable <= (nextBanksReady != '0);

         if (isWriting) begin
            if (bankDone) begin
               writeAddr <= '0;
               if (commitBank) writeBank <= nextWriteBank;
            end else begin
               writeAddr <= writeAddr + 1'b1;
            end
         end

         dataValid <= doPop;
         if (doPop) begin
            popSeen  <= 1'b1;
            readMode <= dataMode;
            if (finalPop) begin
               readAddr <= '0;
               readBank <= nextReadBank;
            end else begin
               readAddr <= readAddr + 1'b1;
            end
         end

         if (overflowEvent) begin
            bufferOverflow <= 1'b1;
            holdCount      <= '0;
            if (overflowCount != 16'hFFFF) overflowCount <= overflowCount + 1'b1;
         end else if (bufferOverflow) begin
            if (holdCount == HOLD_LAST) begin
               bufferOverflow <= 1'b0;
               holdCount      <= '0;
            end else begin
               holdCount <= holdCount + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_bank_buffer.sv
// Directed bench for multi_bank_buffer: a 4-bank instance for the main flows and
// a 2-bank instance for the coincident complete/free case.
module tb_multi_bank_buffer;
   import buffer_pkg::*;

   localparam int DW   = 10;
   localparam int D    = 16;
   localparam int HOLD = 20;

   logic          clock = 1'b0;
   logic          nReset = 1'b0;

   logic          isWriting = 1'b0, isReading = 1'b0, dataMode = 1'b0;
   logic [DW-1:0] dataIn = '0;
   logic [15:0]   dataOut, overflowCount;
   logic          dataValid, dataAvailable, bufferOverflow;
   logic [2:0]    banksReady;

   logic          isWritingB = 1'b0, isReadingB = 1'b0, dataModeB = 1'b0;
   logic [DW-1:0] dataInB = '0;
   logic [15:0]   dataOutB, overflowCountB;
   logic          dataValidB, dataAvailableB, bufferOverflowB;
   logic [1:0]    banksReadyB;

   int passCount  = 0;
   int checkCount = 0;

   multi_bank_buffer #(.DATA_WIDTH(DW), .BANK_DEPTH(D), .NUM_BANKS(4), .OVERFLOW_HOLD(HOLD)) dut (
      .clock(clock), .nReset(nReset), .isWriting(isWriting), .dataIn(dataIn),
      .isReading(isReading), .dataMode(dataMode), .dataOut(dataOut), .dataValid(dataValid),
      .dataAvailable(dataAvailable), .banksReady(banksReady),
      .bufferOverflow(bufferOverflow), .overflowCount(overflowCount)
   );

   multi_bank_buffer #(.DATA_WIDTH(DW), .BANK_DEPTH(D), .NUM_BANKS(2), .OVERFLOW_HOLD(HOLD)) dutB (
      .clock(clock), .nReset(nReset), .isWriting(isWritingB), .dataIn(dataInB),
      .isReading(isReadingB), .dataMode(dataModeB), .dataOut(dataOutB), .dataValid(dataValidB),
      .dataAvailable(dataAvailableB), .banksReady(banksReadyB),
      .bufferOverflow(bufferOverflowB), .overflowCount(overflowCountB)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic writeBurst(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         isWriting = 1'b1;
         dataIn    = DW'(base + i);
         tick();
      end
      isWriting = 1'b0;
   endtask

   task automatic drain(input int first, input int n, input string tag);
      isReading = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, "_valid"}, 32'(dataValid), 1);
         check({tag, "_data"}, 32'(dataOut), 32'(first + i));
      end
      isReading = 1'b0;
   endtask

   initial begin
      int highCycles;

      #12;
      check("rst_dataOut", 32'(dataOut), 0);
      check("rst_dataValid", 32'(dataValid), 0);
      check("rst_avail", 32'(dataAvailable), 0);
      check("rst_banksReady", 32'(banksReady), 0);
      check("rst_overflow", 32'(bufferOverflow), 0);
      check("rst_ovfCount", 32'(overflowCount), 0);
      nReset = 1'b1;
      tick();

      // Basic fill and drain (bank 0)
      writeBurst(0, 15);
      check("fill_avail_early", 32'(dataAvailable), 0);
      writeBurst(15, 1);
      check("fill_avail", 32'(dataAvailable), 1);
      check("fill_banksReady", 32'(banksReady), 1);
      drain(0, D, "basic");
      check("drain_avail", 32'(dataAvailable), 0);
      check("drain_banksReady", 32'(banksReady), 0);
      tick();
      check("idle_valid", 32'(dataValid), 0);
      check("idle_hold", 32'(dataOut), 15);

      // Left-justify (bank 1), mode switched back mid-bank
      isWriting = 1'b1;
      dataIn = 10'h3FF; tick();
      dataIn = 10'h001; tick();
      for (int i = 2; i < D; i++) begin
         dataIn = DW'(i);
         tick();
      end
      isWriting = 1'b0;
      dataMode  = DATA_MODE_LEFT_JUST;
      isReading = 1'b1;
      tick();
      check("lj_3ff", 32'(dataOut), 32'hFFC0);
      tick();
      check("lj_001", 32'(dataOut), 32'h0040);
      dataMode = DATA_MODE_ZERO_EXT;
      isReading = 1'b0;
      drain(2, D - 2, "lj_rest");

      // Read while empty
      isReading = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("empty_valid", 32'(dataValid), 0);
      end
      isReading = 1'b0;

      // Fill to capacity (banks 2,3,0), then one bank more overflows
      writeBurst(0, 3 * D);
      check("full_banksReady", 32'(banksReady), 3);
      check("full_noOverflow", 32'(bufferOverflow), 0);
      writeBurst(100, D);
      check("ovf_flag", 32'(bufferOverflow), 1);
      check("ovf_count", 32'(overflowCount), 1);
      check("ovf_banksReady", 32'(banksReady), 3);
      highCycles = 1;
      for (int i = 0; i < 2 * HOLD; i++) begin
         tick();
         if (!bufferOverflow) break;
         highCycles++;
      end
      check("ovf_hold_cycles", 32'(highCycles), HOLD);
      drain(0, 3 * D, "ovf_drain");
      check("ovf_drain_banksReady", 32'(banksReady), 0);
      check("ovf_drain_avail", 32'(dataAvailable), 0);

      // Mid-operation reset: bank 1 ready, bank 2 partly written
      writeBurst(200, D + 5);
      check("mid_banksReady", 32'(banksReady), 1);
      #2;
      nReset = 1'b0;
      #1;
      check("mid_rst_avail", 32'(dataAvailable), 0);
      check("mid_rst_banksReady", 32'(banksReady), 0);
      check("mid_rst_dataOut", 32'(dataOut), 0);
      check("mid_rst_ovfCount", 32'(overflowCount), 0);
      @(negedge clock);
      nReset = 1'b1;
      tick();
      writeBurst(300, D);
      check("post_rst_banksReady", 32'(banksReady), 1);
      drain(300, D, "post_rst");

      // Two-bank instance: final write coincides with final pop of the read bank
      isWritingB = 1'b1;
      for (int i = 0; i < D; i++) begin
         dataInB = DW'(i);
         tick();
      end
      check("b_banksReady", 32'(banksReadyB), 1);
      isReadingB = 1'b1;
      for (int i = 0; i < D; i++) begin
         dataInB = DW'(D + i);
         tick();
         check("b_stream_data", 32'(dataOutB), 32'(i));
      end
      isWritingB = 1'b0;
      isReadingB = 1'b0;
      check("b_noOverflow", 32'(bufferOverflowB), 0);
      check("b_ovfCount", 32'(overflowCountB), 0);
      check("b_banksReady_kept", 32'(banksReadyB), 1);
      check("b_avail", 32'(dataAvailableB), 1);
      isReadingB = 1'b1;
      for (int i = 0; i < D; i++) begin
         tick();
         check("b_drain_data", 32'(dataOutB), 32'(D + i));
      end
      isReadingB = 1'b0;
      check("b_empty", 32'(banksReadyB), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
